// File: rtl/ori_ram_seq.sv
// ori_ram_seq: slot-based RAM access sequencer for the Orion DRAM/SRAM port.
// Time is split into SLOT_LEN-clock access slots; even slots fetch video,
// odd slots serve the CPU. The slot kind is decided on the edge that opens
// the slot (phase 0) and held until the slot ends.
// Optional macro ORI_CPU_BACKFILL_EN: an even slot with the display window
// closed and a CPU request pending is handed to the CPU instead of idling.
module ori_ram_seq #(
    parameter int unsigned SLOT_LEN = 4,
    parameter int unsigned COLS     = 48,
    parameter int unsigned ROWS     = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    // CPU side
    input  logic       cpu_req_i,
    input  logic       cpu_we_i,
    output logic       cpu_wait_o,
    output logic       cpu_ack_o,
    output logic [7:0] cpu_rdata_o,
    // RAM / address mux side
    input  logic [7:0] ram_rdata_i,
    output logic       cke_ras_n_o,
    output logic       acc_cpu_o,
    output logic       ram_oe_o,
    output logic       ram_we_o,
    // Video side
    input  logic       vid_fetch_en_i,
    input  logic       frame_start_i,
    output logic [5:0] num_col_o,
    output logic [7:0] num_row_o,
    output logic [7:0] vid_data_o,
    output logic       vid_data_vld_o
);

    localparam int unsigned PH_W  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned COL_W = 6;
    localparam int unsigned ROW_W = 8;
    localparam int unsigned DAT_W = 8;

    // Last phase of a slot, and the last phase after which a write strobe
    // may still be driven (write is held in phases 1..SLOT_LEN-2).
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SLOT_LEN - 1);
    localparam logic [PH_W-1:0]  PH_WE_END = PH_W'(SLOT_LEN - 3);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

    // Kind of access carried by the current slot
    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_VID    = 2'd1,
        SLOT_CPU_RD = 2'd2,
        SLOT_CPU_WR = 2'd3
    } slot_e;

    // Slot state
    logic [PH_W-1:0]  r_phase;
    logic             r_odd;
    slot_e            r_slot;
    logic             r_fs_pend;

    // Registered outputs
    logic             r_cke;
    logic             r_acc_cpu;
    logic             r_oe;
    logic             r_we;
    logic             r_ack;
    logic [DAT_W-1:0] r_cpu_rdata;
    logic             r_vld;
    logic [DAT_W-1:0] r_vid_data;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Next-state values
    logic             w_last;
    logic [PH_W-1:0]  w_phase_nxt;
    logic             w_odd_nxt;
    slot_e            w_slot_nxt;
    logic             w_fs_pend_nxt;
    logic             w_cke_nxt;
    logic             w_acc_cpu_nxt;
    logic             w_oe_nxt;
    logic             w_we_nxt;
    logic             w_ack_nxt;
    logic [DAT_W-1:0] w_cpu_rdata_nxt;
    logic             w_vld_nxt;
    logic [DAT_W-1:0] w_vid_data_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic             w_slot_rd;

    // Next-state and next-output logic for the slot sequencer
    always_comb begin
        w_last          = (r_phase == PH_LAST);
        w_phase_nxt     = w_last ? '0 : r_phase + PH_W'(1);
        w_odd_nxt       = w_last ? ~r_odd : r_odd;
        w_slot_nxt      = r_slot;
        w_fs_pend_nxt   = r_fs_pend | frame_start_i;
        w_acc_cpu_nxt   = r_acc_cpu;
        w_cke_nxt       = 1'b0;
        w_oe_nxt        = 1'b0;
        w_we_nxt        = 1'b0;
        w_ack_nxt       = 1'b0;
        w_vld_nxt       = 1'b0;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_vid_data_nxt  = r_vid_data;
        w_col_nxt       = r_col;
        w_row_nxt       = r_row;
        w_slot_rd       = (r_slot == SLOT_VID) || (r_slot == SLOT_CPU_RD);

        // Slot boundary: choose the kind of the slot that opens now
        if (w_last) begin
            if (w_odd_nxt) begin
                w_acc_cpu_nxt = 1'b1;
                if (cpu_req_i) begin
                    w_slot_nxt = cpu_we_i ? SLOT_CPU_WR : SLOT_CPU_RD;
                end else begin
                    w_slot_nxt = SLOT_IDLE;
                end
            end else if (vid_fetch_en_i) begin
                w_acc_cpu_nxt = 1'b0;
                w_slot_nxt    = SLOT_VID;
            end else begin
`ifdef ORI_CPU_BACKFILL_EN
                if (cpu_req_i) begin
                    w_acc_cpu_nxt = 1'b1;
                    w_slot_nxt    = cpu_we_i ? SLOT_CPU_WR : SLOT_CPU_RD;
                end else begin
                    w_acc_cpu_nxt = 1'b0;
                    w_slot_nxt    = SLOT_IDLE;
                end
`else
                w_acc_cpu_nxt = 1'b0;
                w_slot_nxt    = SLOT_IDLE;
`endif
            end
            w_cke_nxt = (w_slot_nxt != SLOT_IDLE);
        end

        // Strobes for phases 1..SLOT_LEN-1 of the running slot
        if (!w_last) begin
            w_oe_nxt = w_slot_rd;
            w_we_nxt = (r_slot == SLOT_CPU_WR) && (r_phase <= PH_WE_END);
        end

        // Completion: capture read data at the end of the last phase
        if (w_last) begin
            case (r_slot)
                SLOT_CPU_RD: begin
                    w_ack_nxt       = 1'b1;
                    w_cpu_rdata_nxt = ram_rdata_i;
                end
                SLOT_CPU_WR: begin
                    w_ack_nxt = 1'b1;
                end
                SLOT_VID: begin
                    w_vld_nxt      = 1'b1;
                    w_vid_data_nxt = ram_rdata_i;
                end
                default: begin
                end
            endcase
        end

        // Video address counters move only on slot boundaries; frame start wins
        if (w_last) begin
            w_fs_pend_nxt = 1'b0;
            if (r_fs_pend || frame_start_i) begin
                w_col_nxt = '0;
                w_row_nxt = '0;
            end else if (r_slot == SLOT_VID) begin
                if (r_col == COL_LAST) begin
                    w_col_nxt = '0;
                    w_row_nxt = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                end else begin
                    w_col_nxt = r_col + COL_W'(1);
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_phase     <= '0;
            r_odd       <= 1'b0;
            r_slot      <= SLOT_IDLE;
            r_fs_pend   <= 1'b0;
            r_cke       <= 1'b0;
            r_acc_cpu   <= 1'b0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_ack       <= 1'b0;
            r_cpu_rdata <= '0;
            r_vld       <= 1'b0;
            r_vid_data  <= '0;
            r_col       <= '0;
            r_row       <= '0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_odd       <= w_odd_nxt;
            r_slot      <= w_slot_nxt;
            r_fs_pend   <= w_fs_pend_nxt;
            r_cke       <= w_cke_nxt;
            r_acc_cpu   <= w_acc_cpu_nxt;
            r_oe        <= w_oe_nxt;
            r_we        <= w_we_nxt;
            r_ack       <= w_ack_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_vld       <= w_vld_nxt;
            r_vid_data  <= w_vid_data_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
        end
    end

    // CPU stall follows the request until the completion pulse
    assign cpu_wait_o     = cpu_req_i & ~r_ack;

    assign cpu_ack_o      = r_ack;
    assign cpu_rdata_o    = r_cpu_rdata;
    assign cke_ras_n_o    = r_cke;
    assign acc_cpu_o      = r_acc_cpu;
    assign ram_oe_o       = r_oe;
    assign ram_we_o       = r_we;
    assign num_col_o      = r_col;
    assign num_row_o      = r_row;
    assign vid_data_o     = r_vid_data;
    assign vid_data_vld_o = r_vld;

endmodule

// File: tb/tb_ori_ram_seq.sv
// tb_ori_ram_seq: directed bench for the Orion RAM access sequencer.
module tb_ori_ram_seq;

`ifdef ORI_CPU_BACKFILL_EN
    localparam int unsigned EXP_ACK_GAP = 4;
`else
    localparam int unsigned EXP_ACK_GAP = 8;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cpu_req_i = 1'b0;
    logic       cpu_we_i = 1'b0;
    logic       cpu_wait_o;
    logic       cpu_ack_o;
    logic [7:0] cpu_rdata_o;
    logic [7:0] ram_rdata_i = 8'h00;
    logic       cke_ras_n_o;
    logic       acc_cpu_o;
    logic       ram_oe_o;
    logic       ram_we_o;
    logic       vid_fetch_en_i = 1'b0;
    logic       frame_start_i = 1'b0;
    logic [5:0] num_col_o;
    logic [7:0] num_row_o;
    logic [7:0] vid_data_o;
    logic       vid_data_vld_o;

    int n_chk = 0;
    int n_err = 0;
    logic follow_col = 1'b0;

    ori_ram_seq dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_req_i      (cpu_req_i),
        .cpu_we_i       (cpu_we_i),
        .cpu_wait_o     (cpu_wait_o),
        .cpu_ack_o      (cpu_ack_o),
        .cpu_rdata_o    (cpu_rdata_o),
        .ram_rdata_i    (ram_rdata_i),
        .cke_ras_n_o    (cke_ras_n_o),
        .acc_cpu_o      (acc_cpu_o),
        .ram_oe_o       (ram_oe_o),
        .ram_we_o       (ram_we_o),
        .vid_fetch_en_i (vid_fetch_en_i),
        .frame_start_i  (frame_start_i),
        .num_col_o      (num_col_o),
        .num_row_o      (num_row_o),
        .vid_data_o     (vid_data_o),
        .vid_data_vld_o (vid_data_vld_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       cke;
        logic       acc;
        logic       oe;
        logic       we;
        logic       ack;
        logic [7:0] crd;
        logic       wt;
        logic       vld;
        logic [7:0] vdat;
        logic [5:0] col;
    } out_t;

    typedef struct packed {
        logic       req;
        logic       we;
        logic [7:0] rdata;
        out_t       exp;
    } vec_t;

    vec_t vt [22];

    function automatic out_t cur_out();
        out_t o;
        o.cke  = cke_ras_n_o;
        o.acc  = acc_cpu_o;
        o.oe   = ram_oe_o;
        o.we   = ram_we_o;
        o.ack  = cpu_ack_o;
        o.crd  = cpu_rdata_o;
        o.wt   = cpu_wait_o;
        o.vld  = vid_data_vld_o;
        o.vdat = vid_data_o;
        o.col  = num_col_o;
        return o;
    endfunction

    function automatic vec_t mk(input logic req, input logic we, input logic [7:0] rd,
                                input logic cke, input logic acc, input logic oe,
                                input logic wen, input logic ack, input logic [7:0] crd,
                                input logic wt, input logic vld, input logic [7:0] vd,
                                input logic [5:0] col);
        vec_t v;
        v.req      = req;
        v.we       = we;
        v.rdata    = rd;
        v.exp.cke  = cke;
        v.exp.acc  = acc;
        v.exp.oe   = oe;
        v.exp.we   = wen;
        v.exp.ack  = ack;
        v.exp.crd  = crd;
        v.exp.wt   = wt;
        v.exp.vld  = vld;
        v.exp.vdat = vd;
        v.exp.col  = col;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (follow_col) ram_rdata_i = 8'(num_col_o);
    endtask

    // Reset for three edges; returns in cycle 0 (phase 0, even slot)
    task automatic do_reset();
        @(negedge clk_i);
        rst_i          = 1'b1;
        cpu_req_i      = 1'b0;
        cpu_we_i       = 1'b0;
        vid_fetch_en_i = 1'b0;
        frame_start_i  = 1'b0;
        follow_col     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int bad;
        int nv;
        int last_cyc;
        int cyc;
        int found;
        int n;
        int nwait;
        int a1;
        int a2;

        // Cycle table: CPU read (req at even phase 2), CPU write, video fetches
        //           req we  rdata  cke acc oe we ack crd    wt vld vdat   col
        vt[0]  = mk(0, 0, 8'hA5,  0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 6'd0);
        vt[1]  = mk(0, 0, 8'hA5,  0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 6'd0);
        vt[2]  = mk(1, 0, 8'hA5,  0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 6'd0);
        vt[3]  = mk(1, 0, 8'hA5,  0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 6'd0);
        vt[4]  = mk(1, 0, 8'hA5,  1, 1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 6'd0);
        vt[5]  = mk(1, 0, 8'hA5,  0, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00, 6'd0);
        vt[6]  = mk(1, 0, 8'hA5,  0, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00, 6'd0);
        vt[7]  = mk(1, 0, 8'hA5,  0, 1, 1, 0, 0, 8'h00, 1, 0, 8'h00, 6'd0);
        vt[8]  = mk(1, 0, 8'hA5,  1, 0, 0, 0, 1, 8'hA5, 0, 0, 8'h00, 6'd0);
        vt[9]  = mk(0, 0, 8'hA5,  0, 0, 1, 0, 0, 8'hA5, 0, 0, 8'h00, 6'd0);
        vt[10] = mk(1, 1, 8'h3C,  0, 0, 1, 0, 0, 8'hA5, 1, 0, 8'h00, 6'd0);
        vt[11] = mk(1, 1, 8'h3C,  0, 0, 1, 0, 0, 8'hA5, 1, 0, 8'h00, 6'd0);
        vt[12] = mk(1, 1, 8'h3C,  1, 1, 0, 0, 0, 8'hA5, 1, 1, 8'h3C, 6'd1);
        vt[13] = mk(1, 1, 8'h3C,  0, 1, 0, 1, 0, 8'hA5, 1, 0, 8'h3C, 6'd1);
        vt[14] = mk(1, 1, 8'h3C,  0, 1, 0, 1, 0, 8'hA5, 1, 0, 8'h3C, 6'd1);
        vt[15] = mk(1, 1, 8'h3C,  0, 1, 0, 0, 0, 8'hA5, 1, 0, 8'h3C, 6'd1);
        vt[16] = mk(1, 1, 8'h3C,  1, 0, 0, 0, 1, 8'hA5, 0, 0, 8'h3C, 6'd1);
        vt[17] = mk(0, 0, 8'h3C,  0, 0, 1, 0, 0, 8'hA5, 0, 0, 8'h3C, 6'd1);
        vt[18] = mk(0, 0, 8'h5A,  0, 0, 1, 0, 0, 8'hA5, 0, 0, 8'h3C, 6'd1);
        vt[19] = mk(0, 0, 8'h5A,  0, 0, 1, 0, 0, 8'hA5, 0, 0, 8'h3C, 6'd1);
        vt[20] = mk(0, 0, 8'h5A,  0, 1, 0, 0, 0, 8'hA5, 0, 1, 8'h5A, 6'd2);
        vt[21] = mk(0, 0, 8'h5A,  0, 1, 0, 0, 0, 8'hA5, 0, 0, 8'h5A, 6'd2);

        do_reset();
        chk("reset_outs", 32'(cur_out()), 32'd0);
        chk("reset_row", 32'(num_row_o), 32'd0);
        vid_fetch_en_i = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i > 0) tick();
            cpu_req_i   = vt[i].req;
            cpu_we_i    = vt[i].we;
            ram_rdata_i = vt[i].rdata;
            #1;
            chk($sformatf("vec%0d", i), 32'(cur_out()), 32'(vt[i].exp));
        end

        // Reset held three cycles in the middle of an active video slot
        do_reset();
        vid_fetch_en_i = 1'b1;
        repeat (9) tick();
        chk("pre_rst_oe", 32'(ram_oe_o), 32'd1);
        rst_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst_zero%0d", k), 32'(cur_out()), 32'd0);
        end
        rst_i = 1'b0;
        first = -1;
        bad   = 0;
        for (int k = 0; k < 20 && first < 0; k++) begin
            if (k > 0) tick();
            if (cke_ras_n_o) first = k;
            if (vid_data_vld_o || cpu_ack_o) bad++;
        end
        chk("first_cke_after_rst", 32'(first), 32'd8);
        chk("no_vld_ack_after_rst", 32'(bad), 32'd0);

        // Full line of video fetches with RAM data equal to the column
        do_reset();
        vid_fetch_en_i = 1'b1;
        follow_col     = 1'b1;
        ram_rdata_i    = 8'h00;
        nv       = 0;
        last_cyc = 0;
        cyc      = 0;
        while (nv < 48 && cyc < 600) begin
            tick();
            cyc++;
            if (vid_data_vld_o) begin
                chk($sformatf("sweep_data%0d", nv), 32'(vid_data_o), 32'(nv));
                if (nv > 0) chk($sformatf("sweep_gap%0d", nv), 32'(cyc - last_cyc), 32'd8);
                last_cyc = cyc;
                nv++;
            end
        end
        chk("sweep_count", 32'(nv), 32'd48);
        chk("wrap_col", 32'(num_col_o), 32'd0);
        chk("wrap_row", 32'(num_row_o), 32'd1);

        // Frame start during the fetch of col 10 / row 5
        found = 0;
        for (int k = 0; k < 2500 && found == 0; k++) begin
            tick();
            if (cke_ras_n_o && !acc_cpu_o && num_col_o == 6'd10 && num_row_o == 8'd5) found = 1;
        end
        chk("fs_found", 32'(found), 32'd1);
        if (found != 0) begin
            frame_start_i = 1'b1;
            tick();
            frame_start_i = 1'b0;
            tick();
            tick();
            chk("fs_addr_hold", 32'({num_row_o, num_col_o}), 32'({8'd5, 6'd10}));
            tick();
            chk("fs_vld", 32'(vid_data_vld_o), 32'd1);
            chk("fs_vdata", 32'(vid_data_o), 32'd10);
            chk("fs_addr_cleared", 32'({num_row_o, num_col_o}), 32'd0);
            repeat (4) tick();
            chk("fs_next_cke", 32'({cke_ras_n_o, acc_cpu_o}), 32'd2);
            chk("fs_next_addr", 32'({num_row_o, num_col_o}), 32'd0);
            repeat (4) tick();
            chk("fs_next_vld", 32'({vid_data_vld_o, vid_data_o}), 32'h100);
            chk("fs_next_col", 32'(num_col_o), 32'd1);
        end

        // Worst-case latency: request just misses the CPU-slot decision
        do_reset();
        vid_fetch_en_i = 1'b1;
        ram_rdata_i    = 8'h77;
        repeat (4) tick();
        chk("idle_cpu_slot_acc", 32'({acc_cpu_o, cke_ras_n_o}), 32'd2);
        cpu_req_i = 1'b1;
        #1;
        n     = 0;
        nwait = 0;
        while (!cpu_ack_o && n < 40) begin
            if (cpu_wait_o) nwait++;
            tick();
            n++;
        end
        chk("lat_clocks", 32'(n), 32'd12);
        chk("lat_wait_cycles", 32'(nwait), 32'd12);
        chk("lat_rdata", 32'(cpu_rdata_o), 32'h77);
        chk("lat_wait_at_ack", 32'(cpu_wait_o), 32'd0);
        tick();
        cpu_req_i = 1'b0;

        // Held request with the display window closed: spacing of acks
        do_reset();
        cpu_req_i = 1'b1;
        a1 = -1;
        a2 = -1;
        for (int k = 0; k < 60 && a2 < 0; k++) begin
            tick();
            if (cpu_ack_o) begin
                if (a1 < 0) a1 = k;
                else a2 = k;
            end
        end
        chk("first_ack_cycle", 32'(a1), 32'd7);
        chk("ack_gap", 32'(a2 - a1), 32'(EXP_ACK_GAP));
        cpu_req_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
